// File: rtl/enigma_sequencer.sv
// Character sequencer for the Enigma rotor chain: launch, collect, step, return.
// Optional rotor watchdog enabled by defining ENIGMA_SEQ_TIMEOUT_EN.
module enigma_sequencer #(
    parameter int NUM_ROTORS = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_load,
    input  logic                  cfg_dec,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_char,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_char,
    output logic                  rot_set,
    output logic                  rot_dec,
    output logic [NUM_ROTORS-1:0] rot_valid,
    output logic [7:0]            rot_din,
    output logic [NUM_ROTORS-1:0] rot_en,
    input  logic [7:0]            rot_dout,
    input  logic [NUM_ROTORS-1:0] rot_done,
    output logic                  busy,
    output logic                  err
);
    localparam int SW = $clog2(NUM_ROTORS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_LAUNCH, S_WAIT, S_STEP, S_OUT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_cur;
    logic [SW-1:0]         r_stage;
    logic                  r_dec;
    logic [4:0]            r_pos [NUM_ROTORS];
    logic [SW-1:0]         w_rot;
    logic [NUM_ROTORS-1:0] w_oh;
    logic [NUM_ROTORS-1:0] w_en;
    logic                  w_hit;
    logic                  w_last;
    logic                  w_letter;
    logic                  w_tmo;

    assign w_rot    = r_dec ? (SW'(NUM_ROTORS - 1) - r_stage) : r_stage;
    assign w_oh     = NUM_ROTORS'(1) << w_rot;
    assign w_hit    = |(rot_done & w_oh);
    assign w_last   = (r_stage + 1'b1) == SW'(NUM_ROTORS);
    assign w_letter = (in_char >= 8'd65) && (in_char <= 8'd90);

    // Odometer carry: rotor k steps only when every lower rotor sits at 25.
    always_comb begin
        logic v_c;
        w_en = '0;
        v_c  = 1'b1;
        for (int k = 0; k < NUM_ROTORS; k++) begin
            w_en[k] = v_c;
            v_c     = v_c & (r_pos[k] == 5'd25);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (cfg_load)      w_next = S_CFG;
                else if (in_valid) w_next = w_letter ? S_LAUNCH : S_OUT;
            end
            S_CFG:    w_next = S_IDLE;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (w_hit)      w_next = w_last ? S_STEP : S_LAUNCH;
                else if (w_tmo) w_next = S_IDLE;
            end
            S_STEP:   w_next = S_OUT;
            S_OUT:    if (out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cur   <= 8'h00;
            r_stage <= '0;
            r_dec   <= 1'b0;
            for (int k = 0; k < NUM_ROTORS; k++) r_pos[k] <= 5'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (cfg_load) begin
                        r_dec <= cfg_dec;
                    end else if (in_valid) begin
                        r_cur   <= in_char;
                        r_stage <= '0;
                    end
                end
                S_CFG: begin
                    for (int k = 0; k < NUM_ROTORS; k++) r_pos[k] <= 5'd0;
                end
                S_WAIT: begin
                    if (w_hit) begin
                        r_cur   <= rot_dout;
                        r_stage <= r_stage + 1'b1;
                    end
                end
                S_STEP: begin
                    for (int k = 0; k < NUM_ROTORS; k++)
                        if (w_en[k])
                            r_pos[k] <= (r_pos[k] == 5'd25) ? 5'd0 : r_pos[k] + 5'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef ENIGMA_SEQ_TIMEOUT_EN
    logic [7:0] r_wdog;
    logic       r_err;

    assign w_tmo = (r_wdog == 8'(TIMEOUT - 1));
    assign err   = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_CFG)
                r_err <= 1'b0;
            else if (r_state == S_WAIT && !w_hit && w_tmo)
                r_err <= 1'b1;
            r_wdog <= (r_state == S_WAIT) ? r_wdog + 8'd1 : 8'd0;
        end
    end
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    assign in_ready  = reset_n && (r_state == S_IDLE) && !cfg_load;
    assign busy      = (r_state != S_IDLE);
    assign rot_set   = (r_state == S_CFG);
    assign rot_dec   = r_dec;
    assign rot_valid = (r_state == S_LAUNCH) ? w_oh : '0;
    assign rot_din   = (r_state == S_LAUNCH) ? r_cur : 8'h00;
    assign rot_en    = (r_state == S_STEP) ? w_en : '0;
    assign out_valid = (r_state == S_OUT);
    assign out_char  = out_valid ? r_cur : 8'h00;
endmodule
